// File: rtl/bola.sv
// bola: ball engine that tracks the paddle, moves on a fixed tick,
// bounces off the walls and the paddle, and reports hits and losses.
module bola #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int SPEED     = 2,
  parameter int TICK_DIV  = 250000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       iniciarBola,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] largura_nave,
  input  logic [9:0] altura_nave,
  output logic [9:0] x_bola,
  output logic [9:0] y_bola,
  output logic       bateu,
  output logic       perdeu
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] HB = 11'(BALL_SIZE / 2);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [10:0] SH = 11'(SCREEN_H);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - BALL_SIZE);

  typedef enum logic [1:0] {PARADA, MOVENDO, PERDIDA} state_t;

  state_t state;
  logic dx, dy;
  logic [CW-1:0] cnt;

  logic [10:0] xb, yb, xn, yn, ln, an, bot, win, tsum;
  logic [9:0] trk_x, trk_y, nx, ny;
  logic hit, lose, left_b, right_b, top_b, ndx, ndy;

  assign xb = {1'b0, x_bola};
  assign yb = {1'b0, y_bola};
  assign xn = {1'b0, x_nave};
  assign yn = {1'b0, y_nave};
  assign ln = {1'b0, largura_nave};
  assign an = {1'b0, altura_nave};
  assign bot = yb + BS;

  // paddle-centred rest position, kept on screen
  assign tsum = xn + (ln >> 1);
  assign trk_x = tsum < HB ? '0 : (tsum - HB > XMAX) ? 10'(XMAX) : 10'(tsum - HB);
  assign trk_y = yn < BS ? '0 : 10'(yn - BS);

  // at speeds above 1px the ball can step past the paddle top, so accept any overlap with the paddle body
  assign win = yn + ((SPEED > 1 && an != '0) ? an - 11'd1 : 11'd0);
  assign hit = dy && bot <= win && bot + SP >= yn && xb + BS > xn && xb < xn + ln;
  assign lose = !hit && dy && bot + SP >= SH;

  assign left_b = !dx && xb < SP;
  assign right_b = dx && xb + BS + SP > SW;
  assign top_b = !dy && yb < SP;
  assign nx = left_b ? '0 : right_b ? 10'(XMAX) : dx ? 10'(xb + SP) : 10'(xb - SP);
  assign ny = hit ? trk_y : top_b ? '0 : dy ? 10'(yb + SP) : 10'(yb - SP);
  assign ndx = hit ? (xb + HB >= xn + (ln >> 1)) : left_b ? 1'b1 : right_b ? 1'b0 : dx;
  assign ndy = hit ? 1'b0 : top_b ? 1'b1 : dy;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= PARADA;
      x_bola <= '0;
      y_bola <= '0;
      bateu <= 1'b0;
      perdeu <= 1'b0;
      dx <= 1'b1;
      dy <= 1'b0;
      cnt <= '0;
    end else if (reiniciarJogo) begin
      state <= PARADA;
      x_bola <= '0;
      y_bola <= '0;
      bateu <= 1'b0;
      perdeu <= 1'b0;
      dx <= 1'b1;
      dy <= 1'b0;
      cnt <= '0;
    end else begin
      bateu <= 1'b0;
      perdeu <= 1'b0;
      if (!pausa) begin
        case (state)
          PARADA: begin
            x_bola <= trk_x;
            y_bola <= trk_y;
            if (iniciarBola) begin
              state <= MOVENDO;
              dx <= 1'b1;
              dy <= 1'b0;
              cnt <= '0;
            end
          end
          MOVENDO: begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (lose) begin
                state <= PERDIDA;
                perdeu <= 1'b1;
              end else begin
                x_bola <= nx;
                y_bola <= ny;
                dx <= ndx;
                dy <= ndy;
                bateu <= hit;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= PARADA;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bola.sv
// tb_bola: randomized play against a rule-level model of the ball engine.
module tb_bola;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pausa = 1'b0, restart = 1'b0, ini = 1'b0;
  int xn = 350, yn = 240, ln = 80, an = 10;
  logic [9:0] x_nave, y_nave, largura_nave, altura_nave;
  logic [9:0] x_bola, y_bola;
  logic bateu, perdeu;

  assign x_nave = xn[9:0];
  assign y_nave = yn[9:0];
  assign largura_nave = ln[9:0];
  assign altura_nave = an[9:0];

  bola #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .reset(rst_n), .pausa(pausa), .reiniciarJogo(restart),
    .iniciarBola(ini), .x_nave(x_nave), .y_nave(y_nave),
    .largura_nave(largura_nave), .altura_nave(altura_nave),
    .x_bola(x_bola), .y_bola(y_bola), .bateu(bateu), .perdeu(perdeu)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // model: mode 0 = resting on paddle, 1 = flying, 2 = lost
  int mode, mx, my, mdx, mdy, mcnt, mb, mp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  task automatic mreset();
    mode = 0; mx = 0; my = 0; mdx = 1; mdy = 0; mcnt = 0; mb = 0; mp = 0;
  endtask

  task automatic mstep();
    int nx, ny, ndx, ndy, bottom;
    bit hit;
    bottom = my + 8;
    hit = mdy == 1 && bottom + 2 >= yn && bottom <= yn + (an > 0 ? an - 1 : 0)
          && mx + 8 > xn && mx < xn + ln;
    if (!hit && mdy == 1 && bottom + 2 >= 480) begin
      mode = 2; mp = 1;
      return;
    end
    ndx = mdx;
    if (mdx == 0 && mx < 2) begin nx = 0; ndx = 1; end
    else if (mdx == 1 && mx + 10 > 640) begin nx = 632; ndx = 0; end
    else nx = mdx == 1 ? mx + 2 : mx - 2;
    ndy = mdy;
    if (hit) begin
      ny = yn - 8; ndy = 0; mb = 1;
      ndx = (mx + 4 < xn + ln / 2) ? 0 : 1;
    end else if (mdy == 0 && my < 2) begin ny = 0; ndy = 1; end
    else ny = mdy == 1 ? my + 2 : my - 2;
    mx = nx; my = ny; mdx = ndx; mdy = ndy;
  endtask

  task automatic model_edge();
    if (!rst_n || restart) mreset();
    else begin
      mb = 0; mp = 0;
      if (pausa) return;
      if (mode == 0) begin
        mx = clampi(xn + ln / 2 - 4, 0, 632);
        my = yn - 8 < 0 ? 0 : yn - 8;
        if (ini) begin mode = 1; mdx = 1; mdy = 0; mcnt = 0; end
      end else if (mode == 2) mode = 0;
      else if (mcnt != TD - 1) mcnt++;
      else begin mcnt = 0; mstep(); end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("x_bola", x_bola, mx);
    chk("y_bola", y_bola, my);
    chk("bateu", bateu, mb);
    chk("perdeu", perdeu, mp);
  endtask

  int ylist[5] = '{440, 455, 401, 300, 460};
  int pause_left = 0, off = 0, hits = 0, losses = 0;
  bit follow = 1'b1;

  initial begin
    mreset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_x", x_bola, 0);
    chk("rst_y", y_bola, 0);
    chk("rst_bateu", bateu, 0);
    chk("rst_perdeu", perdeu, 0);
    rst_n = 1'b1;
    cycle();
    chk("track_x", x_bola, 386);
    chk("track_y", y_bola, 232);
    for (int i = 0; i < 5; i++) cycle();
    chk("track_hold_x", x_bola, 386);
    for (int i = 0; i < 60000 && errors < 40; i++) begin
      restart = $urandom_range(0, 7999) == 0;
      if (pause_left > 0) begin pause_left--; pausa = 1'b1; end
      else begin
        pausa = 1'b0;
        if ($urandom_range(0, 399) == 0) pause_left = $urandom_range(1, 12);
      end
      ini = $urandom_range(0, 49) == 0;
      if (i % 3000 == 0) begin
        ln = $urandom_range(40, 120);
        an = $urandom_range(4, 16);
        yn = ylist[$urandom_range(0, 4)];
        follow = $urandom_range(0, 3) != 0;
        off = int'($urandom_range(0, 60)) - 30;
      end
      if (mode == 1 && follow) xn = clampi(mx + 4 - ln / 2 + off, 0, 640 - ln);
      else if ($urandom_range(0, 199) == 0) xn = $urandom_range(0, 640 - ln);
      if (i == 30000) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_x", x_bola, 0);
        chk("async_rst_y", y_bola, 0);
      end
      if (i == 30002) rst_n = 1'b1;
      cycle();
      hits += mb;
      losses += mp;
    end
    pausa = 1'b0; restart = 1'b0; ini = 1'b1;
    xn = 300; yn = 440; ln = 80;
    cycle();
    ini = 1'b0;
    for (int i = 0; i < 21; i++) cycle();
    pausa = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    restart = 1'b1;
    cycle();
    chk("restart_x", x_bola, 0);
    chk("restart_y", y_bola, 0);
    restart = 1'b0; pausa = 1'b0;
    cycle();
    chk("post_restart_x", x_bola, 336);
    chk("post_restart_y", y_bola, 432);
    if (hits == 0) chk("paddle_hits_seen", hits, 1);
    if (losses == 0) chk("losses_seen", losses, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bola.md
# bola

Ball engine for the paddle game: the counterpart of the paddle (nave) block on the paddle/ball interface. It consumes the paddle's position, size and launch request, moves the ball at a fixed tick rate, and bounces it off the walls and the paddle. It reports each paddle hit back as `bateu` and each ball loss at the bottom as `perdeu`. It sits between the paddle block and the VGA renderer, which reads `x_bola`/`y_bola`.

## Interface
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: ball side length in pixels; square ball.
- `SPEED`, 2: pixels moved per axis per tick.
- `TICK_DIV`, 250000: clocks per movement tick (5 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pausa`  in  1  freezes all motion and the tick counter while 1.
- `reiniciarJogo`  in  1  synchronous restart; same end state as reset.
- `iniciarBola`  in  1  launch request, level-sampled in PARADA.
- `x_nave`, `y_nave`  in  10 each  paddle top-left corner.
- `largura_nave`, `altura_nave`  in  10 each  paddle width and height.
- `x_bola`, `y_bola`  out  10 each  ball top-left corner, registered.
- `bateu`  out  1  one-clock pulse on each paddle hit.
- `perdeu`  out  1  one-clock pulse when the ball passes the bottom edge.

## Operation
- **States:** PARADA (ball rests on the paddle), MOVENDO, PERDIDA.
- **Direction registers:** `dx` (1 = right) and `dy` (1 = down).
- **PARADA, pausa = 0:**
  - Every clock: `x_bola = x_nave + largura_nave/2 − BALL_SIZE/2`, clamped to [0, SCREEN_W−BALL_SIZE].
  - Every clock: `y_bola = y_nave − BALL_SIZE`, clamped to ≥ 0.
  - If `iniciarBola` = 1: go to MOVENDO, set `dx` = 1, `dy` = 0 (up), clear the tick counter.
- **MOVENDO:** the tick counter runs 0..TICK_DIV−1 while pausa = 0. When it reaches TICK_DIV−1 it wraps to 0 and one step is applied. Per step, evaluated on the current registered position (see Timing for how multiple rules combine):
  - **Horizontal:**
    - If `dx` = 0 and `x_bola` < SPEED: `x` = 0, `dx` = 1.
    - Else if `dx` = 1 and `x_bola` + BALL_SIZE + SPEED > SCREEN_W: `x` = SCREEN_W−BALL_SIZE, `dx` = 0.
    - Else: `x` ± SPEED.
  - **Top wall:** if `dy` = 0 and `y_bola` < SPEED: `y` = 0, `dy` = 1.
  - **Paddle hit:** requires all of the following:
    - `dy` = 1;
    - `y_bola` + BALL_SIZE ≤ `y_nave` and `y_bola` + BALL_SIZE + SPEED ≥ `y_nave`;
    - `x_bola` + BALL_SIZE > `x_nave` and `x_bola` < `x_nave` + `largura_nave`.
  - **On a paddle hit:**
    - `y` = `y_nave` − BALL_SIZE, `dy` = 0, `bateu` = 1 for that clock.
    - `dx` = 0 if ball centre < paddle centre, else 1. This overrides the horizontal rule's `dx`.
  - **Bottom:** if there is no paddle hit, `dy` = 1, and `y_bola` + BALL_SIZE + SPEED ≥ SCREEN_H: go to PERDIDA; position is held.
  - **Otherwise:** `y` ± SPEED.
- **PERDIDA:** for one clock, `perdeu` = 1, then go to PARADA.
- **Arithmetic:** all sums and compares use 11-bit unsigned intermediates, so `x_nave` + `largura_nave` never wraps.
- **Paddle height:** `altura_nave` is used only for hit-window widening. The hit window extends to `y_nave` + `altura_nave` − 1 when SPEED > 1, so a ball that tunnels into the paddle top is still caught.

## Timing
- **Reset values:**
  - state PARADA, `x_bola` = 0, `y_bola` = 0;
  - `bateu` = 0, `perdeu` = 0;
  - `dx` = 1, `dy` = 0, tick counter = 0.
- **reiniciarJogo = 1:** the next clock yields the reset values. It has priority over `pausa` and over any pending step, and no pulse is emitted in that clock.
- **Launch:** `iniciarBola` is sampled at edge N. The state is MOVENDO after N, and the first step lands at edge N + TICK_DIV.
- **Step latency:** a step is computed from the registers and committed on the wrap edge, so new `x_bola`/`y_bola` are visible one clock after the counter shows TICK_DIV−1.
- **Pulse timing:** `bateu` is high in the same cycle as the post-bounce position. `perdeu` is high for exactly one cycle, in the PERDIDA state.
- **pausa = 1:**
  - counter, state, position and direction are all held; `bateu` and `perdeu` are forced 0;
  - in PARADA, paddle tracking also freezes;
  - when `pausa` drops, the counter resumes from its held value.
- **Combining rules in one step:**
  - a side-wall and a top-wall bounce in the same step are both applied (corner bounce);
  - a paddle hit takes priority over the bottom-loss check;
  - a side-wall bounce combined with a paddle hit uses the paddle-derived `dx`.
- **Reset mid-tick:** asserting `reset` asynchronously clears everything, including a pending pulse.

## Test plan
Benches use TICK_DIV = 4.
1. **Reset and tracking.** Release reset with paddle at (350, 240), width 80, `iniciarBola` = 0 → `x_bola` = 386, `y_bola` = 232 one clock later, and outputs stay there; `bateu` = `perdeu` = 0.
2. **Launch and top bounce.**
   - Assert `iniciarBola` → `x_bola` +2 and `y_bola` −2 every 4 clocks after launch.
   - With `y_bola` = 1 moving up → next step `y_bola` = 0, then it moves down by 2.
3. **Side walls.**
   - `x_bola` = 631 moving right → `x_bola` = 632, and the next step gives 630.
   - `x_bola` = 1 moving left → 0, then 2.
4. **Paddle hit.**
   - Ball at (360, 230) moving down, paddle at (350, 240) width 80 → `y_bola` = 232, `dy` up.
   - `bateu` is high for exactly one clock; `dx` = 0 because the ball centre 364 < paddle centre 390.
5. **Loss.** Ball at (10, 470) moving down, no paddle overlap → `perdeu` is one clock high, then PARADA tracking resumes on the next clock.
6. **Pause and restart.**
   - `pausa` for 10 clocks mid-flight → position and counter frozen, and no pulses.
   - Then pulse `reiniciarJogo` → reset values on the next clock, even with `pausa` = 1.
